mc_fpu_sequencer: RTL

// - Initiator side of the multi-cycle FP unit en/done protocol used by the RT core ALU (Sqrt, Div).
// - Accepts one op at a time from the decode stage (valid/ready) and pulses en on the selected unit.
// - Holds operands stable until done, captures the result, and presents it to writeback (valid/ready).
// - Isolates the pipeline from unit latency; at most one op is outstanding.

---
 rtl/rt_alu_pkg.sv | 10 +
 rtl/mc_fpu_sequencer_if.sv | 52 +++++
 rtl/mc_watchdog.sv | 27 ++
 rtl/mc_fpu_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/rt_alu_pkg.sv
// Shared types and constants for the RT core ALU multi-cycle FP sequencing.
package rt_alu_pkg;

  typedef enum logic {MC_SQRT = 1'b0, MC_DIV = 1'b1} mc_op_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mc_state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/mc_fpu_sequencer_if.sv
// Decode/unit/writeback signal bundle of the multi-cycle FP sequencer.
// master = sequencer side, slave = decode, Sqrt/Div units and writeback side.
interface mc_fpu_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  import rt_alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  mc_op_e            req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic              sqrt_en;
  logic [DATA_W-1:0] sqrt_in;
  logic              sqrt_done;
  logic [DATA_W-1:0] sqrt_out;

  logic              div_en;
  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic              div_done;
  logic [DATA_W-1:0] div_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output sqrt_en, sqrt_in, input sqrt_done, sqrt_out,
    output div_en, div_a, div_b, input div_done, div_out,
    output rsp_valid, rsp_data, rsp_tag, rsp_err, busy,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  sqrt_en, sqrt_in, output sqrt_done, sqrt_out,
    input  div_en, div_a, div_b, output div_done, div_out,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err, busy,
    output rsp_ready
  );

endinterface

// File: rtl/mc_watchdog.sv
// WAIT-state watchdog: cleared on issue, counts WAIT cycles, fires on the
// cycle the count would reach TIMEOUT_CYC. Only built when MC_TIMEOUT_EN is defined.
`ifdef MC_TIMEOUT_EN
module mc_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic fire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign fire_c = inc && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/mc_fpu_sequencer.sv
// Initiator for the Sqrt/Div en/done protocol; one op outstanding at a time.
// Optional WAIT watchdog enabled by defining MC_TIMEOUT_EN.
module mc_fpu_sequencer
  import rt_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_fpu_sequencer_if.master   bus
);

  if (TIMEOUT_CYC == 0) begin : g_cfg_chk
    $error("mc_fpu_sequencer: TIMEOUT_CYC must be nonzero");
  end

  mc_state_e         state_q, state_d;
  mc_op_e            op_q;
  logic [DATA_W-1:0] a_q, b_q, data_q;
  logic [TAG_W-1:0]  tag_q;

  logic req_ready_c, busy_c, issue_c, wait_c, resp_c;
  logic accept_c, sel_done_c, timeout_c;
  logic [DATA_W-1:0] sel_out_c;

  assign accept_c   = bus.req_valid && req_ready_c;
  assign sel_done_c = (op_q == MC_SQRT) ? bus.sqrt_done : bus.div_done;
  assign sel_out_c  = (op_q == MC_SQRT) ? bus.sqrt_out  : bus.div_out;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sel_done_c || timeout_c) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = 1'b0;
    busy_c      = 1'b0;
    issue_c     = 1'b0;
    wait_c      = 1'b0;
    resp_c      = 1'b0;
    case (state_q)
      IDLE:    req_ready_c = 1'b1;
      ISSUE:   begin busy_c = 1'b1; issue_c = 1'b1; end
      WAIT:    begin busy_c = 1'b1; wait_c  = 1'b1; end
      RESP:    begin busy_c = 1'b1; resp_c  = 1'b1; end
      default: req_ready_c = 1'b0;
    endcase
  end

`ifdef MC_TIMEOUT_EN
  logic err_q;

  mc_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (issue_c),
    .inc    (wait_c),
    .fire_c (timeout_c)
  );

  assign bus.rsp_err = err_q;
`else
  assign timeout_c   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Operand capture on accept; result capture in WAIT (a real done beats the watchdog).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= MC_SQRT;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      data_q <= '0;
`ifdef MC_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
    end else begin
      if (accept_c) begin
        op_q  <= bus.req_op;
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        tag_q <= bus.req_tag;
`ifdef MC_TIMEOUT_EN
        err_q <= 1'b0;
`endif
      end
      if (wait_c && sel_done_c) begin
        data_q <= sel_out_c;
`ifdef MC_TIMEOUT_EN
        err_q  <= 1'b0;
      end else if (timeout_c) begin
        data_q <= DATA_W'(FP_QNAN);
        err_q  <= 1'b1;
`endif
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.busy      = busy_c;
  assign bus.rsp_valid = resp_c;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_tag   = tag_q;

  // Unit operands are live only from ISSUE through WAIT; the unused one stays 0.
  assign bus.sqrt_en = issue_c && (op_q == MC_SQRT);
  assign bus.div_en  = issue_c && (op_q == MC_DIV);
  assign bus.sqrt_in = ((issue_c || wait_c) && (op_q == MC_SQRT)) ? a_q : '0;
  assign bus.div_a   = ((issue_c || wait_c) && (op_q == MC_DIV))  ? a_q : '0;
  assign bus.div_b   = ((issue_c || wait_c) && (op_q == MC_DIV))  ? b_q : '0;

endmodule
